// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
//
// Byte-stream program load channel feeding the instruction memory loader.
// A byte moves on every rising clock edge where ld_valid and ld_ready are
// both high.
//
// Signals:
//   ld_valid  producer -> loader   byte on ld_byte/ld_last is valid
//   ld_ready  loader   -> producer loader can take a byte this cycle
//   ld_byte   producer -> loader   program byte, big-endian within a word
//   ld_last   producer -> loader   final byte of the program (with ld_valid)
// -----------------------------------------------------------------------------
interface imem_loader_if;
    logic       ld_valid;
    logic       ld_ready;
    logic [7:0] ld_byte;
    logic       ld_last;

    modport master (
        output ld_valid,
        output ld_byte,
        output ld_last,
        input  ld_ready
    );

    modport slave (
        input  ld_valid,
        input  ld_byte,
        input  ld_last,
        output ld_ready
    );
endinterface

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Instruction memory plus program loader placed in front of the pipelined
// MIPS core. A program arrives as a big-endian byte stream; bytes are packed
// into 32-bit words and written to consecutive memory words. While loading,
// the core is held in reset; after the final byte the reset is held for
// HOLD_CYCLES more edges so the core's internal reset chain drains, then the
// core runs and fetches instructions combinationally from this memory.
//
// Ports:
//   CLK           clock, all state changes on the rising edge
//   RSTn          asynchronous active-low reset
//   ld            load channel (slave side): ld_valid/ld_ready/ld_byte/ld_last
//   reload        single-cycle request to start a new load (RELEASE/RUN only)
//   PC            core program counter, byte address
//   Instr         instruction word for PC, NOP when not readable
//   core_RSTn     registered active-low reset to the core
//   load_done     high while the core is running
//   word_count    number of words written by the current load
//   err_overflow  sticky flag, program was longer than DEPTH words
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int DEPTH       = 128,
    parameter int AW          = 7,
    parameter int HOLD_CYCLES = 4
) (
    input  logic          CLK,
    input  logic          RSTn,
    imem_loader_if.slave  ld,
    input  logic          reload,
    input  logic [31:0]   PC,
    output logic [31:0]   Instr,
    output logic          core_RSTn,
    output logic          load_done,
    output logic [AW:0]   word_count,
    output logic          err_overflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } state_t;

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [3:0]  HOLD_INIT  = 4'(HOLD_CYCLES);

    state_t        state;
    state_t        state_next;
    logic          core_rstn_next;

    logic [1:0]    byte_idx;
    logic [31:0]   shift_word;
    logic [3:0]    hold_cnt;
    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          write_due;
    logic          overflow;
    logic          do_write;
    logic          reload_take;
    logic [31:0]   merged_word;

    logic [AW-1:0] rd_idx;
    logic          rd_in_range;
    logic          unused_pc_bits;

    // ------------------------------------------------------------------
    // Handshake and write qualification
    // ------------------------------------------------------------------
    assign ld.ld_ready  = (state == IDLE) || (state == LOAD);
    assign accept       = ld.ld_valid && ld.ld_ready;
    assign write_due    = accept && ((byte_idx == 2'd3) || ld.ld_last);
    assign overflow     = write_due && (word_count == FULL_COUNT);
    assign do_write     = write_due && !overflow;
    assign reload_take  = reload && ((state == RELEASE) || (state == RUN));
    assign load_done    = (state == RUN);

    // The partially built word with the incoming byte dropped into its lane.
    // Lanes not yet filled are still zero because the buffer is cleared after
    // every write, which gives the zero padding for a short final word.
    always_comb begin
        merged_word = shift_word;
        case (byte_idx)
            2'd0:    merged_word[31:24] = ld.ld_byte;
            2'd1:    merged_word[23:16] = ld.ld_byte;
            2'd2:    merged_word[15:8]  = ld.ld_byte;
            default: merged_word[7:0]   = ld.ld_byte;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= IDLE;
            core_RSTn <= 1'b0;
        end else begin
            state     <= state_next;
            core_RSTn <= core_rstn_next;
        end
    end

    // The hold counter is loaded with HOLD_CYCLES on the ld_last edge, so the
    // edge that sees it at 1 is the HOLD_CYCLES-th one after that edge.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, LOAD: begin
                if (accept) begin
                    state_next = ld.ld_last ? RELEASE : LOAD;
                end
            end
            RELEASE: begin
                if (reload) begin
                    state_next = IDLE;
                end else if (hold_cnt <= 4'd1) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (reload) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        core_rstn_next = (state_next == RUN);
    end

    // ------------------------------------------------------------------
    // Load datapath: byte lane index, word buffer, counters, error flag
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            byte_idx     <= 2'd0;
            shift_word   <= 32'h0;
            word_count   <= '0;
            hold_cnt     <= 4'd0;
            err_overflow <= 1'b0;
        end else if (reload_take) begin
            byte_idx     <= 2'd0;
            shift_word   <= 32'h0;
            word_count   <= '0;
            hold_cnt     <= 4'd0;
            err_overflow <= 1'b0;
        end else if (accept) begin
            if (write_due) begin
                byte_idx   <= 2'd0;
                shift_word <= 32'h0;
            end else begin
                byte_idx   <= byte_idx + 2'd1;
                shift_word <= merged_word;
            end
            if (do_write) begin
                word_count <= word_count + 1'b1;
            end
            if (overflow) begin
                err_overflow <= 1'b1;
            end
            if (ld.ld_last) begin
                hold_cnt <= HOLD_INIT;
            end
        end else if ((state == RELEASE) && (hold_cnt != 4'd0)) begin
            hold_cnt <= hold_cnt - 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Instruction memory. No reset so it maps onto plain RAM; stale words
    // are hidden by word_count. Writes are blocked while RSTn is low since
    // the FSM sits in IDLE (ready) during reset.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (do_write && RSTn) begin
            mem[word_count[AW-1:0]] <= merged_word;
        end
    end

    // ------------------------------------------------------------------
    // Combinational fetch. Anything not backed by a word of the current
    // program reads as 32'h0, which the core decodes as a NOP.
    // ------------------------------------------------------------------
    assign rd_idx         = PC[AW+1:2];
    assign rd_in_range    = (PC[31:AW+2] == '0);
    assign unused_pc_bits = ^PC[1:0];

    always_comb begin
        Instr = 32'h0;
        if ((state == RUN) && rd_in_range && ({1'b0, rd_idx} < word_count)) begin
            Instr = mem[rd_idx];
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader. A behavioural model (byte queue,
// word array, countdown to release) predicts every output each cycle; a
// compare process checks the DUT against it one time unit after every rising
// edge. Directed sequences pin the model with literal expectations; random
// rounds then exercise the handshake, reload and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int DEPTH = 128;
    localparam int AW    = 7;
    localparam int HOLD  = 4;

    logic          CLK = 1'b0;
    logic          RSTn;
    logic          reload;
    logic [31:0]   PC;
    logic [31:0]   Instr;
    logic          core_RSTn;
    logic          load_done;
    logic [AW:0]   word_count;
    logic          err_overflow;

    imem_loader_if ld ();

    imem_loader #(
        .DEPTH       (DEPTH),
        .AW          (AW),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .ld           (ld),
        .reload       (reload),
        .PC           (PC),
        .Instr        (Instr),
        .core_RSTn    (core_RSTn),
        .load_done    (load_done),
        .word_count   (word_count),
        .err_overflow (err_overflow)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // ------------------------------------------------------------------
    // Behavioural model: phase 0 = taking bytes, 1 = counting down to
    // release, 2 = core running.
    // ------------------------------------------------------------------
    logic [31:0] m_mem [DEPTH];
    int          m_wc    = 0;
    bit          m_err   = 1'b0;
    int          m_phase = 0;
    int          m_left  = 0;
    logic [7:0]  m_cur [$];

    always @(posedge CLK or negedge RSTn) begin
        logic [31:0] w;
        if (!RSTn) begin
            m_phase = 0;
            m_wc    = 0;
            m_err   = 1'b0;
            m_left  = 0;
            m_cur.delete();
        end else begin
            case (m_phase)
                0: begin
                    if (ld.ld_valid) begin
                        m_cur.push_back(ld.ld_byte);
                        if (m_cur.size() == 4 || ld.ld_last) begin
                            w = 32'h0;
                            for (int i = 0; i < m_cur.size(); i++) begin
                                w = w | (32'(m_cur[i]) << (24 - 8 * i));
                            end
                            if (m_wc == DEPTH) begin
                                m_err = 1'b1;
                            end else begin
                                m_mem[m_wc] = w;
                                m_wc++;
                            end
                            m_cur.delete();
                        end
                        if (ld.ld_last) begin
                            m_phase = 1;
                            m_left  = HOLD;
                        end
                    end
                end
                1: begin
                    if (reload) begin
                        m_phase = 0; m_wc = 0; m_err = 1'b0; m_cur.delete();
                    end else begin
                        m_left--;
                        if (m_left == 0) m_phase = 2;
                    end
                end
                default: begin
                    if (reload) begin
                        m_phase = 0; m_wc = 0; m_err = 1'b0; m_cur.delete();
                    end
                end
            endcase
        end
    end

    function automatic logic [31:0] exp_instr(input logic [31:0] pc);
        int idx;
        idx = int'((pc >> 2) & 32'(DEPTH - 1));
        if (m_phase == 2 && (pc >> (AW + 2)) == 32'h0 && idx < m_wc) return m_mem[idx];
        return 32'h0;
    endfunction

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_output(input string tag);
        cmp({tag, ".ld_ready"},     32'(ld.ld_ready),    32'(m_phase == 0));
        cmp({tag, ".core_RSTn"},    32'(core_RSTn),      32'(m_phase == 2));
        cmp({tag, ".load_done"},    32'(load_done),      32'(m_phase == 2));
        cmp({tag, ".word_count"},   32'(word_count),     32'(m_wc));
        cmp({tag, ".err_overflow"}, 32'(err_overflow),   32'(m_err));
        cmp({tag, ".Instr"},        Instr,               exp_instr(PC));
    endtask

    always begin
        @(posedge CLK);
        #1;
        check_output("cycle");
    end

    // ------------------------------------------------------------------
    // Stimulus helpers; all driving happens on the falling edge
    // ------------------------------------------------------------------
    function automatic logic [31:0] random_pc();
        logic [31:0] p;
        case ($urandom_range(0, 7))
            0:       p = $urandom;
            1:       p = 32'($urandom_range(0, DEPTH + 4)) * 4 + 32'($urandom_range(0, 3));
            default: p = 32'($urandom_range(0, 12)) * 4 + 32'($urandom_range(0, 3));
        endcase
        return p;
    endfunction

    // junk=1 offers random bytes only while the model says the loader is busy,
    // so those bytes must be ignored.
    task automatic apply_stimulus(input bit junk, input logic v, input logic [7:0] b,
                                  input logic l, input logic rl, input logic [31:0] pc);
        @(negedge CLK);
        if (junk) begin
            ld.ld_valid = (m_phase != 0) && ($urandom_range(0, 1) == 1);
            ld.ld_byte  = 8'($urandom);
            ld.ld_last  = 1'($urandom);
        end else begin
            ld.ld_valid = v;
            ld.ld_byte  = b;
            ld.ld_last  = l;
        end
        reload = rl;
        PC     = pc;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int gap;
        gap = $urandom_range(0, 2);
        for (int i = 0; i < gap; i++) apply_stimulus(1'b0, 1'b0, b, 1'b0, 1'b0, random_pc());
        apply_stimulus(1'b0, 1'b1, b, last, 1'b0, random_pc());
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b1, 1'b0, 8'h0, 1'b0, 1'b0, random_pc());
    endtask

    task automatic pulse_reload(input logic [31:0] pc);
        apply_stimulus(1'b0, 1'b0, 8'h0, 1'b0, 1'b1, pc);
    endtask

    task automatic wait_run(input string name);
        int n;
        n = 0;
        while (core_RSTn !== 1'b1 && n < 20) begin
            apply_stimulus(1'b1, 1'b0, 8'h0, 1'b0, 1'b0, random_pc());
            n++;
        end
        cmp({name, ".reached_run"}, 32'(core_RSTn), 32'd1);
    endtask

    task automatic peek(input string name, input logic [31:0] pc, input logic [31:0] exp);
        PC = pc;
        #1;
        cmp(name, Instr, exp);
    endtask

    task automatic async_reset(input string name);
        ld.ld_valid = 1'b0;
        reload      = 1'b0;
        PC          = 32'h0;
        #2 RSTn = 1'b0;
        #1;
        cmp({name, ".core_RSTn"}, 32'(core_RSTn), 32'd0);
        cmp({name, ".ld_ready"},  32'(ld.ld_ready), 32'd1);
        cmp({name, ".load_done"}, 32'(load_done), 32'd0);
        cmp({name, ".Instr"},     Instr, 32'h0);
        check_output(name);
        @(negedge CLK);
        RSTn = 1'b1;
    endtask

    logic [7:0] prog1 [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
    logic [7:0] prog2 [3] = '{8'hAC, 8'h01, 8'h00};
    logic [7:0] prog3 [4] = '{8'h12, 8'h34, 8'h56, 8'h78};

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] w;
        ld.ld_valid = 1'b0;
        ld.ld_byte  = 8'h0;
        ld.ld_last  = 1'b0;
        reload      = 1'b0;
        PC          = 32'h0;
        RSTn        = 1'b1;
        #2 RSTn = 1'b0;
        #1;
        cmp("reset.core_RSTn",    32'(core_RSTn), 32'd0);
        cmp("reset.word_count",   32'(word_count), 32'd0);
        cmp("reset.ld_ready",     32'(ld.ld_ready), 32'd1);
        cmp("reset.err_overflow", 32'(err_overflow), 32'd0);
        cmp("reset.Instr",        Instr, 32'h0);
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;

        // Two-word program, back to back, then count release edges exactly
        for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 1'b1, prog1[i], i == 7, 1'b0, 32'h0);
        apply_stimulus(1'b0, 1'b0, 8'h07, 1'b0, 1'b0, 32'h0);
        for (int k = 1; k <= HOLD; k++) begin
            @(posedge CLK);
            #1;
            cmp($sformatf("hold_edge%0d", k), 32'(core_RSTn), 32'(k == HOLD));
        end
        cmp("prog1.word_count", 32'(word_count), 32'd2);
        cmp("prog1.load_done",  32'(load_done), 32'd1);
        peek("prog1.pc0", 32'h0, 32'h20080005);
        peek("prog1.pc4", 32'h4, 32'h20090007);
        peek("prog1.pc6", 32'h6, 32'h20090007);
        peek("prog1.pc8", 32'h8, 32'h00000000);
        idle_cycles(4);

        // Reload from RUN drops the core on the next edge
        pulse_reload(32'h0);
        @(posedge CLK);
        #1;
        cmp("reload.core_RSTn",  32'(core_RSTn), 32'd0);
        cmp("reload.word_count", 32'(word_count), 32'd0);
        cmp("reload.Instr",      Instr, 32'h0);

        // Partial final word is zero padded
        for (int i = 0; i < 3; i++) send_byte(prog2[i], i == 2);
        wait_run("prog2");
        cmp("prog2.word_count", 32'(word_count), 32'd1);
        peek("prog2.pc0", 32'h0, 32'hAC010000);
        peek("prog2.pc4", 32'h4, 32'h0);
        idle_cycles(3);
        pulse_reload(random_pc());

        // Overflow: DEPTH+1 words
        for (int k = 0; k <= DEPTH; k++) begin
            w = 32'hA5000000 | 32'(k);
            for (int b = 0; b < 4; b++) send_byte(8'(w >> (24 - 8 * b)), k == DEPTH && b == 3);
        end
        wait_run("ovf");
        cmp("ovf.err_overflow", 32'(err_overflow), 32'd1);
        cmp("ovf.word_count",   32'(word_count), 32'd128);
        peek("ovf.first", 32'h0, 32'hA5000000);
        peek("ovf.last",  32'(DEPTH - 1) * 4, 32'hA500007F);
        peek("ovf.beyond", 32'(DEPTH) * 4, 32'h0);
        idle_cycles(3);
        pulse_reload(random_pc());

        // New one-word program after reload; error flag was cleared
        for (int i = 0; i < 4; i++) send_byte(prog3[i], i == 3);
        wait_run("prog3");
        cmp("prog3.err_overflow", 32'(err_overflow), 32'd0);
        peek("prog3.pc0", 32'h0, 32'h12345678);
        peek("prog3.high", 32'h80000000, 32'h0);
        idle_cycles(2);
        pulse_reload(random_pc());

        // Async reset in the middle of a load, then in RUN
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0);
        apply_stimulus(1'b0, 1'b0, 8'h0, 1'b0, 1'b0, 32'h0);
        async_reset("arst_load");
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), i == 3);
        wait_run("arst_prog");
        idle_cycles(3);
        async_reset("arst_run");

        // Random programs with irregular valid, junk offers, reloads, resets
        for (int r = 0; r < 30; r++) begin
            int n;
            n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) send_byte(8'($urandom), i == n - 1);
            if ($urandom_range(0, 4) == 0) begin
                idle_cycles($urandom_range(0, 2));
                pulse_reload(random_pc());
                idle_cycles(2);
            end else begin
                wait_run("rand");
                idle_cycles($urandom_range(5, 15));
                if ($urandom_range(0, 3) == 0) begin
                    async_reset("rand_arst");
                end else begin
                    pulse_reload(random_pc());
                end
                idle_cycles(2);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        errors++;
        $display("[TB] FAIL watchdog: actual=timeout required=finish at %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
